// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares a single uart_tx byte transmitter between NUM_REQ byte sources.
// Each source offers bytes with valid/ready; a source keeps the transmitter
// for a whole frame, which ends with the byte flagged by req_last. Frames are
// granted round-robin. Every byte offered to uart_tx is followed by one
// guard cycle with tx_data_valid low so the transmitter can drop its ready.
//
// Optional feature (macro UART_ARB_TAG_EN): after each grant a header byte
// 8'h41 + grant_id ('A', 'B', ...) is sent ahead of the first payload byte.
// The header is skipped when a requester whose lock just timed out is
// granted again straight away, since it is continuing the same frame.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   req_data       byte from requester i at bits [8i+7:8i]
//   req_valid      requester i has a byte
//   req_last       byte from requester i ends its frame
//   req_ready      byte from requester i accepted this cycle
//   tx_data        byte to uart_tx
//   tx_data_valid  byte offer to uart_tx
//   tx_data_ready  uart_tx able to accept
//   grant_id       index of current or last granted requester
//   busy           frame in progress (state != IDLE)
//
// State | meaning
//   IDLE  | waiting for any req_valid, picks round-robin winner
//   TAG   | (UART_ARB_TAG_EN only) loads header byte for the new grant
//   LOAD  | accepting next byte from the granted requester, timeout runs
//   SEND  | offering tx_data until uart_tx takes it
//   GUARD | one cycle with valid low, then end frame or fetch next byte
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    input  logic                 tx_data_ready,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy
);

    // Counter runs 0..LOCK_TIMEOUT-1; the cycle it sits at the top value
    // without a byte is the last idle cycle before the lock is dropped.
    localparam int TMO_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
`ifdef UART_ARB_TAG_EN
        ST_TAG   = 3'd4,
`endif
        ST_LOAD  = 3'd1,
        ST_SEND  = 3'd2,
        ST_GUARD = 3'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              last_q, last_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
`ifdef UART_ARB_TAG_EN
    logic              tmo_rel_q, tmo_rel_d;
`endif

    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic [7:0]        sel_byte;
    logic              sel_valid;
    logic              sel_last;
    logic [ID_W-1:0]   nxt_ptr;

    // Round-robin winner: first pass covers indices at or above the pointer,
    // second pass wraps around to the ones below it.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!win_found && req_valid[j] && (j >= int'(ptr_q))) begin
                win_found = 1'b1;
                win_id    = ID_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!win_found && req_valid[j] && (j < int'(ptr_q))) begin
                win_found = 1'b1;
                win_id    = ID_W'(j);
            end
        end
    end

    // Granted requester's lane, selected with constant indices only.
    always_comb begin
        sel_byte  = 8'h00;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_id_q == ID_W'(j)) begin
                sel_byte  = req_data[8*j +: 8];
                sel_valid = req_valid[j];
                sel_last  = req_last[j];
            end
        end
    end

    always_comb begin
        if (int'(grant_id_q) == NUM_REQ - 1) begin
            nxt_ptr = '0;
        end else begin
            nxt_ptr = grant_id_q + 1'b1;
        end
    end

    always_comb begin
        req_ready = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if ((state_q == ST_LOAD) && (grant_id_q == ID_W'(j))) begin
                req_ready[j] = req_valid[j];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        tx_data_d  = tx_data_q;
        last_d     = last_q;
        tmo_d      = tmo_q;
`ifdef UART_ARB_TAG_EN
        tmo_rel_d  = tmo_rel_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_id_d = win_id;
                    tmo_d      = '0;
`ifdef UART_ARB_TAG_EN
                    tmo_rel_d  = 1'b0;
                    if (tmo_rel_q && (win_id == grant_id_q)) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_TAG;
                    end
`else
                    state_d    = ST_LOAD;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG: begin
                tx_data_d = 8'h41 + 8'(grant_id_q);
                last_d    = 1'b0;
                state_d   = ST_SEND;
            end
`endif
            ST_LOAD: begin
                if (sel_valid) begin
                    tx_data_d = sel_byte;
                    last_d    = sel_last;
                    tmo_d     = '0;
                    state_d   = ST_SEND;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d     = '0;
                    ptr_d     = nxt_ptr;
                    state_d   = ST_IDLE;
`ifdef UART_ARB_TAG_EN
                    tmo_rel_d = 1'b1;
`endif
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_SEND: begin
                // No timeout here: a stalled uart_tx is waited on forever.
                if (tx_data_ready) begin
                    state_d = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (last_q) begin
                    ptr_d   = nxt_ptr;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_id_q <= '0;
            ptr_q      <= '0;
            tx_data_q  <= 8'h00;
            last_q     <= 1'b0;
            tmo_q      <= '0;
`ifdef UART_ARB_TAG_EN
            tmo_rel_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            tx_data_q  <= tx_data_d;
            last_q     <= last_d;
            tmo_q      <= tmo_d;
`ifdef UART_ARB_TAG_EN
            tmo_rel_q  <= tmo_rel_d;
`endif
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_data_valid = (state_q == ST_SEND);
    assign grant_id      = grant_id_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one `uart_tx` byte transmitter between NUM_REQ independent byte sources, such as button reporters and status loggers.
- Each source presents bytes with a valid/ready handshake. A source may lock the transmitter for a multi-byte frame, which ends at its `req_last` byte.
- Arbitration between frames is round-robin.
- Sits between the requesters and `uart_tx`, driving its `tx_data` / `tx_data_valid` and consuming its `tx_data_ready`.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of `grant_id`; 2^ID_W >= NUM_REQ.
- LOCK_TIMEOUT, 1024, idle cycles inside a frame before the lock is forcibly released (>= 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_data  in  NUM_REQ*8  byte from requester i at bits [8i+7:8i]
- req_valid  in  NUM_REQ  requester i has a byte
- req_last  in  NUM_REQ  byte from requester i ends its frame
- req_ready  out  NUM_REQ  byte from requester i accepted this cycle
- tx_data  out  8  byte to `uart_tx`
- tx_data_valid  out  1  byte offer to `uart_tx`
- tx_data_ready  in  1  `uart_tx` idle / able to accept
- grant_id  out  ID_W  index of current or last granted requester
- busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - `tx_data` = 8'h00, `tx_data_valid` = 0, `req_ready` = 0, `grant_id` = 0, `busy` = 0.
  - Round-robin pointer = 0, so requester 0 wins first. Timeout counter = 0. State = IDLE.
  - Reset mid-frame abandons the frame immediately; no partial handshake survives.
- State machine: IDLE, TAG (macro only), LOAD, SEND, GUARD.
- IDLE:
  - If any `req_valid` is set, the winner is the first set bit searching from the pointer upward, with wrap.
  - Register `grant_id` = winner, then go to LOAD (TAG if enabled).
  - `req_valid` bits of non-granted requesters are ignored until the frame ends.
- LOAD:
  - `req_ready[grant_id]` = `req_valid[grant_id]` (combinational, only in LOAD). All other `req_ready` bits = 0.
  - On handshake: `tx_data` <= byte, store the last flag, clear the timeout counter, go to SEND.
  - Without `req_valid`: increment the timeout counter. When it reaches LOCK_TIMEOUT, go to IDLE, pointer = `grant_id`+1 mod NUM_REQ.
- SEND:
  - `tx_data_valid` = 1 and `tx_data` is held stable until a cycle with `tx_data_ready` = 1 (transfer).
  - Next cycle: `tx_data_valid` = 0, go to GUARD.
- GUARD:
  - Exactly one cycle with valid low, so `uart_tx` can drop ready.
  - If the stored last flag = 1: go to IDLE, pointer = `grant_id`+1 mod NUM_REQ. Otherwise go to LOAD.
- Latency:
  - A `req_valid` present in IDLE gives `req_ready` at cycle +1 and `tx_data_valid` at cycle +2, assuming `uart_tx` is ready.
  - Minimum spacing between consecutive `tx_data_valid` assertions is 3 cycles; the line rate dominates in practice.
- Boundary conditions:
  - Simultaneous requests in IDLE: resolved by round-robin only; no starvation.
  - A single requester with `req_last` held high gets one byte per arbitration.
  - `tx_data_ready` low throughout SEND: wait indefinitely; the timeout applies only in LOAD.
  - A requester dropping `req_valid` mid-frame keeps the lock until timeout.
  - `req_last` is sampled only at handshake.
- `busy` = 1 in every state except IDLE.

Optional Feature:
- Macro: `UART_ARB_TAG_EN`.
- Defined:
  - After each grant, the TAG state sends a header byte before the first payload byte: 8'h41 + `grant_id` (ASCII 'A', 'B', ...).
  - TAG loads `tx_data`, then behaves as SEND → GUARD → LOAD.
  - Not sent again within the frame, nor on a timeout re-grant.
- Undefined: no TAG state; the first payload byte goes to the output directly.

Test Plan:
- Reset: `rst_n` low mid-SEND → `tx_data_valid` = 0, `req_ready` = 0, `busy` = 0, `grant_id` = 0 immediately. After release, requester 0 is the first winner.
- Single byte: req 1 offers 8'h31 with last=1, `uart_tx` ready → `req_ready[1]` at +1, `tx_data` = 8'h31 with `tx_data_valid` at +2. Valid is held until ready, then GUARD, then IDLE, `grant_id` = 1.
- Round-robin: reqs 0, 2, 3 all valid with last=1 → output byte order 0, 2, 3, 0, 2, 3. Req 1 is never granted.
- Frame lock: req 2 sends "HI\n" (last on 8'h0A) while req 0 is also valid → bytes 8'h48, 8'h49, 8'h0A are contiguous before any req 0 byte.
- Backpressure and timeout:
  - `tx_data_ready` held low for 500 cycles in SEND → `tx_data` is stable, one transfer only.
  - Req 1 stalls mid-frame → after LOCK_TIMEOUT idle cycles in LOAD, IDLE is entered and req 2 is granted.
- `UART_ARB_TAG_EN`: req 3 sends 8'h58 with last=1 → output 8'h44 then 8'h58. Without the macro, only 8'h58 is output.
